// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, BCD digit width and the add-3 threshold.
package bin2bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble adjust step.
// Adds 3 to digits >= 5; illegal codes 10..15 collapse to 0.
import bin2bcd_pkg::*;

module bcd_digit_adj (
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  // Conditional add-3 with defensive clamp of non-BCD codes
  always_comb begin
    d_o = d_i;
    if (d_i > 4'd9) begin
      d_o = '0;
    end else if (d_i >= ADD3_TH) begin
      d_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one operand bit per cycle.
// Define BIN2BCD_SIGNED_EN for two's-complement operands with sign output.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      sign
);

  localparam int SW = BCD_W * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag;
  logic             neg;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scr_q[g*BCD_W +: BCD_W]),
      .d_o (adj[g*BCD_W +: BCD_W])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sgnp_q, sgnp_d;
  logic sgn_q, sgn_d;

  // Operand magnitude; the most-negative value maps to 2^(WIDTH-1)
  always_comb begin
    neg = bin_in[WIDTH-1];
    mag = neg ? -bin_in : bin_in;
  end
`else
  // Unsigned operands pass straight through
  always_comb begin
    neg = 1'b0;
    mag = bin_in;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath next values
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          op_d    = mag;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        scr_d = {adj[SW-2:0], op_q[WIDTH-1]};
        op_d  = {op_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          bcd_d   = scr_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else begin
      op_q  <= op_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  // Sign captured at accept, published on entry to DONE
  always_comb begin
    sgnp_d = sgnp_q;
    sgn_d  = sgn_q;
    if (state_q == IDLE && start) sgnp_d = neg;
    if (state_q == SHIFT && cnt_q == LAST) sgn_d = sgnp_q;
  end

  // Sign registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgnp_q <= 1'b0;
      sgn_q  <= 1'b0;
    end else begin
      sgnp_q <= sgnp_d;
      sgn_q  <= sgn_d;
    end
  end

  assign sign = sgn_q;
`else
  assign sign = neg;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: random and directed operands
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int W = 16;
  localparam int D = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  bin_in = '0;
  logic          busy;
  logic          done;
  logic [4*D-1:0] bcd_out;
  logic          sign;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic           s;
    int             edge_e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .sign    (sign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t model(logic [W-1:0] v, int acc);
    exp_t e;
    longint unsigned m;
    m = v;
    e.s = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[W-1]) begin
      e.s = 1'b1;
      m = (longint'(1) << W) - longint'(v);
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.edge_e = acc + W;
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT presents done
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (prev_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_width: done high two cycles at edge %0d", edge_cnt);
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: done at edge %0d with none expected", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("bcd_out", bcd_out, e.bcd);
        chk("sign", sign, e.s);
        chk("done_edge", edge_cnt, e.edge_e);
      end
    end
    prev_done = done;
  end

  task automatic wait_e(int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Issue one conversion; call at a negedge
  task automatic go(logic [W-1:0] v);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    bin_in = v;
    start  = 1'b1;
    sb.push_back(model(v, edge_cnt + 1));
    @(negedge clk);
    start  = 1'b0;
    bin_in = W'($urandom);
  endtask

  initial begin
    int a;
    logic [W-1:0] dir [6];
    dir = '{16'd0, 16'd65535, 16'd9999, 16'hFFFF, 16'h8000, 16'd1};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_sign", sign, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First start right after reset release
    go(16'd0);
    drain();

    foreach (dir[i]) begin
      go(dir[i]);
      drain();
    end

    // start pulses during a conversion must be ignored
    bin_in = 16'd1234;
    start  = 1'b1;
    a = edge_cnt + 1;
    sb.push_back(model(16'd1234, a));
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'd4444;
    wait_e(a + 2); start = 1'b1;
    wait_e(a + 3); start = 1'b0;
    wait_e(a + 15); start = 1'b1;
    wait_e(a + 16); start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("idle_after_ignored", busy, 0);

    // Reset mid-conversion aborts with no done
    bin_in = 16'd4321;
    start  = 1'b1;
    a = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    wait_e(a + 7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go(16'd4321);
    drain();

    // start held across three back-to-back conversions
    bin_in = 16'd7;
    start  = 1'b1;
    a = edge_cnt + 1;
    sb.push_back(model(16'd7, a));
    sb.push_back(model(16'd80, a + 18));
    sb.push_back(model(16'd900, a + 36));
    wait_e(a); bin_in = 16'd80;
    wait_e(a + 18); bin_in = 16'd900;
    wait_e(a + 36); start = 1'b0; bin_in = 16'd5;
    drain();

    // Randomized operands with random idle gaps
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(W'($urandom));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
